// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access slave controller.
// Holds the default instruction codes, the frame positions (counted in sck rises
// from 1 after ss_n falls), the status byte bit positions and the FSM/decode enums.
package spi_pkg;

    typedef logic [31:0] word_t;
    typedef logic [6:0]  rise_t;

    localparam logic [7:0] DEF_WRITE_INSTR = 8'h00;
    localparam logic [7:0] DEF_READ_INSTR  = 8'h01;

    // Frame layout in sck rises.
    localparam rise_t INSTR_END  = 7'd8;
    localparam rise_t GAP        = 7'd9;
    localparam rise_t ADDR_END   = 7'd41;
    localparam rise_t WDATA_END  = 7'd73;
    localparam rise_t RD_FIRST   = 7'd49;
    localparam rise_t RD_LAST    = 7'd80;
    localparam rise_t STAT_FIRST = 7'd81;
    localparam rise_t FRAME_END  = 7'd88;

    // The first response bit is driven on the falling edge that follows this rise.
    localparam rise_t RD_DEADLINE = RD_FIRST - 7'd1;
    localparam rise_t WR_DEADLINE = STAT_FIRST - 7'd1;

    // Status byte: {5'b0, bad_instr, timeout, ok}.
    localparam int unsigned STAT_OK_BIT      = 0;
    localparam int unsigned STAT_TIMEOUT_BIT = 1;
    localparam int unsigned STAT_BAD_BIT     = 2;

    typedef enum logic [3:0] {
        StIdle,
        StInstr,
        StGap,
        StAddr,
        StWdata,
        StDummy,
        StRdata,
        StStat,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        KindWrite,
        KindRead,
        KindBad
    } kind_e;

endpackage

// File: rtl/spi_reg_slave_ctrl_if.sv
// Internal register bus between the SPI slave controller and the register block.
// master: controller side (drives bus_req/bus_we/bus_addr/bus_wdata).
// slave : register block side (drives bus_ack/bus_rdata).
// bus_req is held until a single-cycle bus_ack; bus_rdata is valid with bus_ack.
interface spi_reg_slave_ctrl_if
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    word_t             bus_wdata;
    logic              bus_ack;
    word_t             bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input with single-cycle edge pulses.
// Ports:
//   clk   system clock
//   rst_n synchronous active-low reset (chain loads RESET_VAL)
//   din   asynchronous input
//   rise  one clk pulse on a synchronised 0->1 transition
//   fall  one clk pulse on a synchronised 1->0 transition
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_reg_slave_ctrl.sv
// SPI (CPOL=0, CPHA=0) register-access slave controller.
// Decodes one frame per ss_n assertion: instruction byte, gap bit, 32-bit address,
// then 32-bit write data or a dummy byte, and runs one register bus transaction.
// Read data (reads) and a status byte are shifted out on miso, MSB first.
// Ports:
//   clk, rst_n      system clock (>= 8x sck) and synchronous active-low reset
//   sck, ss_n, mosi asynchronous SPI inputs, oversampled in the clk domain
//   miso            SPI data to the master (registered)
//   rbus            register bus, master modport
module spi_reg_slave_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  WRITE_INSTR = DEF_WRITE_INSTR,
    parameter logic [7:0]  READ_INSTR  = DEF_READ_INSTR,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sck,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    spi_reg_slave_ctrl_if.master rbus
);

    logic sck_rise, sck_fall;
    logic ss_rise, ss_fall;

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sck (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // ss_n idles high, so its chain resets high to avoid a false frame start.
    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_ss (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ss_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    state_e            state;
    kind_e             kind;
    rise_t             rcnt;
    rise_t             rnext;
    logic [30:0]       sh;
    word_t             shin;
    logic [ADDR_W-1:0] addr_q;
    word_t             rdata_q;
    logic [39:0]       out_sr;
    // own_req: the outstanding request belongs to this frame and its deadline is open.
    logic              own_req;
    logic              acked;

    logic              ack;
    logic              own_ack;
    logic              ok_now;
    logic              bad;
    word_t             rd_word;
    logic [7:0]        status;
    logic [39:0]       resp;
    logic              at_deadline;

    assign rnext   = rcnt + 7'd1;
    assign shin    = {sh, mosi_s};
    assign ack     = rbus.bus_ack & rbus.bus_req;
    assign own_ack = ack & own_req;
    // An ack landing on the deadline cycle still counts as on time.
    assign ok_now  = acked | own_ack;
    assign bad     = (kind == KindBad);
    assign rd_word = acked ? rdata_q : (own_ack ? rbus.bus_rdata : 32'h0);

    assign at_deadline = (state == StDummy) && sck_fall &&
                         (rcnt == ((kind == KindRead) ? RD_DEADLINE : WR_DEADLINE));

    always_comb begin
        status                   = 8'h00;
        status[STAT_BAD_BIT]     = bad;
        status[STAT_TIMEOUT_BIT] = !bad && !ok_now;
        status[STAT_OK_BIT]      = !bad && ok_now;
    end

    // Reads return 32 data bits then status; writes and bad instructions only status.
    assign resp = (kind == KindRead) ? {rd_word, status} : {status, 32'h0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= StIdle;
            kind           <= KindBad;
            rcnt           <= '0;
            sh             <= '0;
            addr_q         <= '0;
            rdata_q        <= '0;
            out_sr         <= '0;
            own_req        <= 1'b0;
            acked          <= 1'b0;
            miso           <= 1'b0;
            rbus.bus_req   <= 1'b0;
            rbus.bus_we    <= 1'b0;
            rbus.bus_addr  <= '0;
            rbus.bus_wdata <= '0;
        end else begin
            // Bus completion runs independently of the frame, so an outstanding
            // request finishes even after the frame that issued it is gone.
            if (ack) begin
                rbus.bus_req <= 1'b0;
                own_req      <= 1'b0;
                if (own_req) begin
                    rdata_q <= rbus.bus_rdata;
                    acked   <= 1'b1;
                end
            end

            if (ss_rise) begin
                state   <= StIdle;
                own_req <= 1'b0;
                miso    <= 1'b0;
            end else if (ss_fall) begin
                state   <= StInstr;
                rcnt    <= '0;
                kind    <= KindBad;
                own_req <= 1'b0;
                acked   <= 1'b0;
                miso    <= 1'b0;
            end else if (state != StIdle) begin
                if (sck_rise) begin
                    rcnt <= rnext;
                    sh   <= shin[30:0];
                    unique case (state)
                        StInstr: begin
                            if (rnext == INSTR_END) begin
                                if (shin[7:0] == WRITE_INSTR) begin
                                    kind <= KindWrite;
                                end else if (shin[7:0] == READ_INSTR) begin
                                    kind <= KindRead;
                                end else begin
                                    kind <= KindBad;
                                end
                                state <= StGap;
                            end
                        end
                        StGap: begin
                            if (rnext == GAP) begin
                                state <= StAddr;
                            end
                        end
                        StAddr: begin
                            if (rnext == ADDR_END) begin
                                addr_q <= shin[ADDR_W-1:0];
                                state  <= (kind == KindWrite) ? StWdata : StDummy;
                                // A still-busy bus means this frame's access is
                                // skipped and later reported as a timeout.
                                if (kind == KindRead && !rbus.bus_req) begin
                                    rbus.bus_req  <= 1'b1;
                                    rbus.bus_we   <= 1'b0;
                                    rbus.bus_addr <= shin[ADDR_W-1:0];
                                    own_req       <= 1'b1;
                                end
                            end
                        end
                        StWdata: begin
                            if (rnext == WDATA_END) begin
                                state <= StDummy;
                                if (!rbus.bus_req) begin
                                    rbus.bus_req   <= 1'b1;
                                    rbus.bus_we    <= 1'b1;
                                    rbus.bus_addr  <= addr_q;
                                    rbus.bus_wdata <= shin;
                                    own_req        <= 1'b1;
                                end
                            end
                        end
                        StRdata: begin
                            if (rnext == RD_LAST) begin
                                state <= StStat;
                            end
                        end
                        StStat: begin
                            if (rnext == FRAME_END) begin
                                state <= StDone;
                                miso  <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end else if (at_deadline) begin
                    // Late acks after this point are discarded.
                    own_req <= 1'b0;
                    miso    <= resp[39];
                    out_sr  <= {resp[38:0], 1'b0};
                    state   <= (kind == KindRead) ? StRdata : StStat;
                end else if (sck_fall && (state == StRdata || state == StStat)) begin
                    miso   <= out_sr[39];
                    out_sr <= {out_sr[38:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave_ctrl.sv
module tb_spi_reg_slave_ctrl;
    import spi_pkg::*;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic sck;
    logic ss_n;
    logic mosi;
    logic miso;

    int checks = 0;
    int errors = 0;

    // Register bus responder configuration and observations.
    bit          ack_en    = 1'b1;
    int          ack_delay = 3;
    logic [31:0] rd_val    = 32'h0;
    int          req_count = 0;
    logic        last_we;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;

    logic [39:0] rx;
    int          base;

    spi_reg_slave_ctrl_if #(.ADDR_W(32)) bus ();

    spi_reg_slave_ctrl #(
        .SYNC_STAGES(2),
        .WRITE_INSTR(8'h00),
        .READ_INSTR (8'h01),
        .ADDR_W     (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sck  (sck),
        .ss_n (ss_n),
        .mosi (mosi),
        .miso (miso),
        .rbus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic half();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    // Master side of one frame; captures miso at rises 49..88 into rxo.
    task automatic spi_frame(input logic [7:0] ins, input logic [31:0] addr,
                             input logic [31:0] wd, input int nrises,
                             input bit end_frame, output logic [39:0] rxo);
        logic [87:0] tx;
        tx   = {ins, 1'b0, addr, wd, 15'h0};
        rxo  = '0;
        mosi = tx[87];
        ss_n = 1'b0;
        half();
        for (int k = 1; k <= nrises; k++) begin
            if (k >= 49) rxo = {rxo[38:0], miso};
            sck = 1'b1;
            half();
            sck = 1'b0;
            if (k < 88) mosi = tx[87-k];
            half();
        end
        if (end_frame) begin
            ss_n = 1'b1;
            mosi = 1'b0;
            half();
        end
    endtask

    // Register block model: acks ack_delay cycles after bus_req rises.
    initial begin
        logic prev_req;
        int   wait_cnt;
        prev_req      = 1'b0;
        wait_cnt      = 0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'hFFFF_FFFF;
        forever begin
            @(posedge clk);
            #1;
            bus.bus_ack   = 1'b0;
            bus.bus_rdata = 32'hFFFF_FFFF;
            if (bus.bus_req === 1'b1) begin
                if (!prev_req) begin
                    req_count++;
                    last_we    = bus.bus_we;
                    last_addr  = bus.bus_addr;
                    last_wdata = bus.bus_wdata;
                end
                wait_cnt++;
                if (ack_en && wait_cnt >= ack_delay) begin
                    bus.bus_ack   = 1'b1;
                    bus.bus_rdata = rd_val;
                    wait_cnt      = 0;
                end
            end else begin
                wait_cnt = 0;
            end
            prev_req = (bus.bus_req === 1'b1);
        end
    end

    initial begin
        rst_n = 1'b0;
        sck   = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_miso", 64'(miso), 64'(0));
        check("rst_req", 64'(bus.bus_req), 64'(0));
        check("rst_we", 64'(bus.bus_we), 64'(0));
        check("rst_addr", 64'(bus.bus_addr), 64'(0));
        check("rst_wdata", 64'(bus.bus_wdata), 64'(0));
        check("rst_rcnt", 64'(dut.rcnt), 64'(0));
        rst_n = 1'b1;
        half();

        // Write, ack after 3 clk.
        ack_en = 1'b1; ack_delay = 3;
        spi_frame(8'h00, 32'h0000_0010, 32'hCAFE_F00D, 88, 1'b1, rx);
        check("wr_req_count", 64'(req_count), 64'(1));
        check("wr_we", 64'(last_we), 64'(1));
        check("wr_addr", 64'(last_addr), 64'h10);
        check("wr_wdata", 64'(last_wdata), 64'hCAFE_F00D);
        check("wr_miso_zero", 64'(rx[39:8]), 64'(0));
        check("wr_status", 64'(rx[7:0]), 64'h01);
        check("wr_req_low", 64'(bus.bus_req), 64'(0));

        // Read, ack after 5 clk.
        ack_delay = 5; rd_val = 32'h1234_5678;
        spi_frame(8'h01, 32'h0000_0020, 32'h0, 88, 1'b1, rx);
        check("rd_req_count", 64'(req_count), 64'(2));
        check("rd_we", 64'(last_we), 64'(0));
        check("rd_addr", 64'(last_addr), 64'h20);
        check("rd_data", 64'(rx[39:8]), 64'h1234_5678);
        check("rd_status", 64'(rx[7:0]), 64'h01);

        // Read never acked before the deadline.
        ack_en = 1'b0; rd_val = 32'hBAD0_BAD0;
        spi_frame(8'h01, 32'h0000_0030, 32'h0, 88, 1'b1, rx);
        check("to_req_count", 64'(req_count), 64'(3));
        check("to_data", 64'(rx[39:8]), 64'(0));
        check("to_status", 64'(rx[7:0]), 64'h02);
        check("to_req_held", 64'(bus.bus_req), 64'(1));
        ack_en = 1'b1; ack_delay = 1;
        repeat (10) @(posedge clk);
        #1;
        check("to_late_ack_drop", 64'(bus.bus_req), 64'(0));
        rd_val = 32'h8765_4321; ack_delay = 2;
        spi_frame(8'h01, 32'h0000_0024, 32'h0, 88, 1'b1, rx);
        check("rd2_addr", 64'(last_addr), 64'h24);
        check("rd2_data", 64'(rx[39:8]), 64'h8765_4321);
        check("rd2_status", 64'(rx[7:0]), 64'h01);

        // Unknown instruction.
        base = req_count;
        spi_frame(8'h5A, 32'h0000_0050, 32'h1111_2222, 88, 1'b1, rx);
        check("bad_no_req", 64'(req_count), 64'(base));
        check("bad_data", 64'(rx[39:8]), 64'(0));
        check("bad_status", 64'(rx[7:0]), 64'h04);

        // ss_n raised after rise 20 of a write.
        base = req_count;
        spi_frame(8'h00, 32'h0000_0060, 32'h5555_AAAA, 20, 1'b1, rx);
        half();
        check("abort_no_req", 64'(req_count), 64'(base));
        check("abort_idle", 64'(dut.state), 64'(StIdle));
        check("abort_req_low", 64'(bus.bus_req), 64'(0));
        ack_delay = 3;
        spi_frame(8'h00, 32'h0000_0064, 32'h0BAD_F00D, 88, 1'b1, rx);
        check("wr2_req_count", 64'(req_count), 64'(base + 1));
        check("wr2_wdata", 64'(last_wdata), 64'h0BAD_F00D);
        check("wr2_status", 64'(rx[7:0]), 64'h01);

        // Reset during the write dummy phase with bus_req high.
        ack_en = 1'b0;
        spi_frame(8'h00, 32'h0000_0040, 32'hDEAD_BEEF, 76, 1'b0, rx);
        check("rstm_state_dummy", 64'(dut.state), 64'(StDummy));
        check("rstm_req_high", 64'(bus.bus_req), 64'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstm_miso", 64'(miso), 64'(0));
        check("rstm_req", 64'(bus.bus_req), 64'(0));
        check("rstm_we", 64'(bus.bus_we), 64'(0));
        check("rstm_addr", 64'(bus.bus_addr), 64'(0));
        check("rstm_wdata", 64'(bus.bus_wdata), 64'(0));
        ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1; ack_en = 1'b1; ack_delay = 4;
        half();
        rd_val = 32'hA5A5_0F0F;
        spi_frame(8'h01, 32'h0000_0070, 32'h0, 88, 1'b1, rx);
        check("rd3_addr", 64'(last_addr), 64'h70);
        check("rd3_data", 64'(rx[39:8]), 64'hA5A5_0F0F);
        check("rd3_status", 64'(rx[7:0]), 64'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave_ctrl.md
Name: spi_reg_slave_ctrl

Overview:
- Register-access controller on the DUT side of the SPI link (CPOL=0, CPHA=0 only).
- Oversamples `sck`, `ss_n` and `mosi` in the system clock domain and decodes the fixed frame: instruction byte, 1 gap bit, 32-bit address, then either 32-bit write data or a dummy byte.
- Issues one req/ack transaction on the internal register bus per frame.
- Returns read data and a status byte on `miso` in time for the SPI master.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on `sck`, `ss_n` and `mosi`. Minimum 2.
- WRITE_INSTR, 8'h00, instruction code for a write.
- READ_INSTR, 8'h01, instruction code for a read.
- ADDR_W, 32, width of `bus_addr`. Takes the LSBs of the 32-bit SPI address.

Ports:
- clk  input  1  system clock. Must be at least 8x the `sck` frequency.
- rst_n  input  1  synchronous, active-low reset.
- sck  input  1  SPI clock (asynchronous).
- ss_n  input  1  SPI slave select, active low (asynchronous).
- mosi  input  1  SPI data from the master.
- miso  output  1  SPI data to the master.
- bus_req  output  1  register bus request. Held high until `bus_ack`.
- bus_we  output  1  1 = write, 0 = read. Valid while `bus_req` is high.
- bus_addr  output  ADDR_W  register address.
- bus_wdata  output  32  write data.
- bus_ack  input  1  single-cycle completion strobe from the register bus.
- bus_rdata  input  32  read data. Valid when `bus_ack` is high.

Behaviour:
- Reset values: `miso`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, FSM in IDLE, rise counter `rcnt`=0.
- Synchronisation and edges: the three inputs pass through SYNC_STAGES flip-flops. A rising edge of synced `sck` samples the synced `mosi` and increments `rcnt` (rises counted from 1 after `ss_n` falls). A falling edge of synced `sck` shifts `miso`. All bits are MSB first.
- Frame, counted in `sck` rises:
  - Instruction: rises 1-8.
  - Gap: rise 9 (bit ignored).
  - Address: rises 10-41.
  - Write: data on rises 42-73, dummy on 74-81, status on 81-88.
  - Read: dummy on 42-49, data on 49-80, status on 81-88.
  - The master samples `miso` at each listed rise, so each response bit is driven on the preceding `sck` falling edge.
- FSM states and transitions:
  - IDLE -> INSTR when synced `ss_n` falls.
  - INSTR -> GAP after rise 8. The instruction is latched here.
  - GAP -> ADDR after rise 9.
  - ADDR -> WDATA (write) or DUMMY (read/unknown) after rise 41.
  - WDATA -> DUMMY after rise 73.
  - DUMMY -> RDATA (read) or STAT (write/unknown).
  - RDATA -> STAT after rise 80.
  - STAT -> DONE after rise 88.
  - DONE -> IDLE when `ss_n` goes high.
  - From any state, `ss_n` going high -> IDLE.
- Bus access:
  - Read: `bus_req` is raised in the clk cycle after rise 41. `bus_rdata` is captured on `bus_ack`.
  - Write: `bus_req` is raised in the clk cycle after rise 73.
  - `bus_req` drops in the cycle after `bus_ack`. There is at most one outstanding request.
- Deadline: the falling edge before the first response bit (read: before rise 49; write: before rise 81).
  - If `bus_ack` has not arrived by the deadline: timeout status bit is set and the read data shifted out is 32'h0.
  - `bus_req` stays high until the late ack. The late ack is discarded.
  - If `bus_req` is still high when a new frame reaches its issue point, that frame's access is skipped with timeout status.
- Status byte: {5'b0, bad_instr, timeout, ok}.
  - ok=1 only when the access was acked by the deadline.
  - Success returns 8'h01.
- Unknown instruction: no bus access, data bits shifted out as 0, status 8'h04.
- `miso` is 0 outside RDATA/STAT and for the write dummy phase.
- `ss_n` high mid-frame: return to IDLE, no request issued if the issue point has not been reached. An outstanding `bus_req` completes normally.
- rst_n low mid-frame: everything returns to reset values, including dropping `bus_req`.

Decomposition:
- Package spi_pkg:
  - WRITE_INSTR/READ_INSTR defaults.
  - Frame rise constants: INSTR_END=8, GAP=9, ADDR_END=41, WDATA_END=73, RD_FIRST=49, STAT_FIRST=81, FRAME_END=88.
  - Status bit indices.
  - FSM state enum.
- Sub-module spi_sync_edge: N-stage synchroniser plus rise/fall pulse outputs, instantiated for `sck` and `ss_n`. `mosi` is synchronised only.

Test Plan:
- Write addr 32'h0000_0010, data 32'hCAFE_F00D, ack after 3 clk -> one `bus_req` with `bus_we`=1, matching addr/wdata; status returned 8'h01.
- Read addr 32'h0000_0020, `bus_rdata`=32'h1234_5678, ack after 5 clk -> master reads 32'h1234_5678, status 8'h01, `bus_we`=0.
- Read with ack never asserted before the deadline -> data 32'h0, status 8'h02. A subsequent read that is acked correctly returns fresh data and status 8'h01.
- Instruction 8'h5A -> no `bus_req`, data 0, status 8'h04.
- `ss_n` raised after rise 20 of a write -> no `bus_req`, FSM in IDLE. The next full write succeeds with 8'h01.
- rst_n asserted during DUMMY with `bus_req` high -> all outputs 0 on the next clk. A following read completes normally.
